// File: rtl/ai_vec_mac_wb_if.sv
// Wishbone slave bus bundle for the vector MAC engine, plus a debug view of
// the engine FSM state (0 = idle, 1 = run, 2 = drain).
interface ai_vec_mac_wb_if;
  logic        wishbone_cyc_i;
  logic        wishbone_stb_i;
  logic [31:0] wishbone_addr_i;
  logic        wishbone_we_i;
  logic [31:0] wishbone_data_i;
  logic [31:0] wishbone_data_o;
  logic        wishbone_ack;
  logic [1:0]  dbg_state;

  // Handshake: a request is cyc & stb while ack is low. The slave raises ack
  // for exactly one cycle after the sampling edge. Read data is valid only
  // while ack is high, and a write takes effect at the sampling edge.
  modport slave (
    input  wishbone_cyc_i, wishbone_stb_i, wishbone_addr_i,
    input  wishbone_we_i, wishbone_data_i,
    output wishbone_data_o, wishbone_ack, dbg_state
  );

  modport master (
    output wishbone_cyc_i, wishbone_stb_i, wishbone_addr_i,
    output wishbone_we_i, wishbone_data_i,
    input  wishbone_data_o, wishbone_ack, dbg_state
  );
endinterface

// File: rtl/ai_vec_mac_wb.sv
// Wishbone-slave dot-product engine. The host loads the operand buffers A and
// B, writes LEN and starts a run. Each RUN cycle reads one word from each
// buffer into registers. The next stage sums the LANES lane products into a
// pipeline register, and the stage after that adds the sum into the
// accumulator. DRAIN holds the FSM until the pipeline has emptied, so busy
// stays high for LEN+2 cycles.
module ai_vec_mac_wb #(
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 16,
  parameter int ACC_W  = 32
) (
  input  logic           wishbone_clk_i,
  input  logic           wishbone_rst_i,
  ai_vec_mac_wb_if.slave bus,
  output logic           irq_o
);
  localparam int LANES  = 32 / ELEM_W;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = 2 * ELEM_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  logic [31:0] a_mem [DEPTH];
  logic [31:0] b_mem [DEPTH];

  state_e             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               ovf_q, ovf_d, err_q, err_d;
  logic               sgn_q, sgn_d, irq_en_q, irq_en_d;
  logic [8:0]         len_q, len_d;
  logic [ACC_W-1:0]   acc_q, acc_d, result_q, result_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [31:0]        rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic               rd_vld_q, rd_vld_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               sum_vld_q, sum_vld_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;

  // Address decode: only byte-address bits [11:2] select a location.
  logic [9:0]    word;
  logic [AW-1:0] buf_idx;
  logic          req, wr, idle, in_buf, sel_reg, sel_a, sel_b, len_ok;
  logic          a_we, b_we;
  logic          unused_addr;

  assign word        = bus.wishbone_addr_i[11:2];
  assign unused_addr = ^{bus.wishbone_addr_i[31:12], bus.wishbone_addr_i[1:0]};
  assign buf_idx     = word[AW-1:0];
  assign req         = bus.wishbone_cyc_i & bus.wishbone_stb_i & ~ack_q;
  assign wr          = req & bus.wishbone_we_i;
  assign idle        = (state_q == ST_IDLE);
  assign in_buf      = ({1'b0, word[7:0]} < 9'(DEPTH));
  assign sel_reg     = (word[9:2] == 8'd0);
  assign sel_a       = (word[9:8] == 2'b01) & in_buf;
  assign sel_b       = (word[9:8] == 2'b10) & in_buf;
  assign len_ok      = (len_q != 9'd0) && (len_q <= 9'(DEPTH));
  assign a_we        = wr & sel_a & idle;
  assign b_we        = wr & sel_b & idle;

  assign bus.wishbone_ack    = ack_q;
  assign bus.wishbone_data_o = dat_q;
  assign bus.dbg_state       = state_q;
  assign irq_o               = done_q & irq_en_q;

  // Sum of the lane products of the registered operand words, extended per mode.
  logic [ELEM_W-1:0] ea, eb;
  logic [PROD_W-1:0] xa, xb, prod;
  logic [SUM_W-1:0]  prod_ext;
  always_comb begin
    sum_d    = '0;
    ea       = '0;
    eb       = '0;
    xa       = '0;
    xb       = '0;
    prod     = '0;
    prod_ext = '0;
    for (int l = 0; l < LANES; l++) begin
      ea = rd_a_q[l*ELEM_W +: ELEM_W];
      eb = rd_b_q[l*ELEM_W +: ELEM_W];
      if (sgn_q) begin
        xa = PROD_W'($signed(ea));
        xb = PROD_W'($signed(eb));
      end else begin
        xa = PROD_W'(ea);
        xb = PROD_W'(eb);
      end
      prod = xa * xb;
      if (sgn_q) prod_ext = SUM_W'($signed(prod));
      else       prod_ext = SUM_W'(prod);
      sum_d = sum_d + prod_ext;
    end
  end

  // Wide add of accumulator and lane sum; overflow means the exact result
  // does not fit in ACC_W bits in the current mode.
  logic [EXT_W-1:0] acc_ext, sum_ext, tot;
  logic             step_ovf;
  always_comb begin
    if (sgn_q) begin
      acc_ext = EXT_W'($signed(acc_q));
      sum_ext = EXT_W'($signed(sum_q));
    end else begin
      acc_ext = EXT_W'(acc_q);
      sum_ext = EXT_W'(sum_q);
    end
    tot = acc_ext + sum_ext;
    if (sgn_q) step_ovf = (tot[EXT_W-1:ACC_W-1] != '0) && (tot[EXT_W-1:ACC_W-1] != '1);
    else       step_ovf = (tot[EXT_W-1:ACC_W] != '0);
  end

  // Read mux for bus reads; unmapped locations read as zero.
  logic [31:0] rdata, res_ext;
  always_comb begin
    if (sgn_q) res_ext = 32'($signed(result_q));
    else       res_ext = 32'(result_q);
    rdata = '0;
    if (sel_reg) begin
      case (word[1:0])
        2'd0:    rdata = {28'd0, irq_en_q, sgn_q, 2'b00};
        2'd1:    rdata = {28'd0, err_q, ovf_q, done_q, busy_q};
        2'd2:    rdata = {23'd0, len_q};
        default: rdata = res_ext;
      endcase
    end else if (sel_a) begin
      rdata = a_mem[buf_idx];
    end else if (sel_b) begin
      rdata = b_mem[buf_idx];
    end
  end

  // Next state: datapath pipeline, FSM sequencing, then host commands in idle.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    sgn_d     = sgn_q;
    irq_en_d  = irq_en_q;
    len_d     = len_q;
    acc_d     = acc_q;
    result_d  = result_q;
    idx_d     = idx_q;
    rd_a_d    = rd_a_q;
    rd_b_d    = rd_b_q;
    rd_vld_d  = 1'b0;
    sum_vld_d = rd_vld_q;
    ack_d     = req;
    dat_d     = (req & ~bus.wishbone_we_i) ? rdata : 32'd0;

    if (sum_vld_q) begin
      acc_d = tot[ACC_W-1:0];
      if (step_ovf) ovf_d = 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        rd_a_d   = a_mem[idx_q];
        rd_b_d   = b_mem[idx_q];
        rd_vld_d = 1'b1;
        if (9'(idx_q) == len_q - 9'd1) state_d = ST_DRAIN;
        else                           idx_d   = idx_q + 1'b1;
      end
      ST_DRAIN: begin
        if (!rd_vld_q) begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_d;
        end
      end
      default: ;
    endcase

    if (wr && sel_reg && word[1:0] == 2'd0) begin
      irq_en_d = bus.wishbone_data_i[3];
      if (idle) begin
        sgn_d = bus.wishbone_data_i[2];
        if (bus.wishbone_data_i[1]) begin
          acc_d    = '0;
          result_d = '0;
          done_d   = 1'b0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
        end
        if (bus.wishbone_data_i[0]) begin
          if (len_ok) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            acc_d   = '0;
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
    if (wr && sel_reg && word[1:0] == 2'd2 && idle) len_d = bus.wishbone_data_i[8:0];
  end

  // Control, status, pipeline and bus-response registers.
  always_ff @(posedge wishbone_clk_i) begin
    if (wishbone_rst_i) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      sgn_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      len_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      rd_vld_q  <= 1'b0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      sgn_q     <= sgn_d;
      irq_en_q  <= irq_en_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      rd_a_q    <= rd_a_d;
      rd_b_q    <= rd_b_d;
      rd_vld_q  <= rd_vld_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  // Operand buffers: host writes only while idle, contents survive reset.
  always_ff @(posedge wishbone_clk_i) begin
    if (a_we) a_mem[buf_idx] <= bus.wishbone_data_i;
    if (b_we) b_mem[buf_idx] <= bus.wishbone_data_i;
  end
endmodule

// File: tb/tb_ai_vec_mac_wb.sv
// Bench for ai_vec_mac_wb: a default instance (ACC_W=32) and an ACC_W=20
// instance share one host driver, and sel picks the instance being accessed.
// Expected results come from an integer dot-product model.
module tb_ai_vec_mac_wb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic        irq0, irq1;
  int          n_assert = 0;
  int          n_fail = 0;
  int          busy_total = 0;
  logic [31:0] a_m [16];
  logic [31:0] b_m [16];

  ai_vec_mac_wb_if bus0 ();
  ai_vec_mac_wb_if bus1 ();

  assign bus0.wishbone_cyc_i  = cyc & ~sel;
  assign bus0.wishbone_stb_i  = stb;
  assign bus0.wishbone_addr_i = adr;
  assign bus0.wishbone_we_i   = we;
  assign bus0.wishbone_data_i = wdat;
  assign bus1.wishbone_cyc_i  = cyc & sel;
  assign bus1.wishbone_stb_i  = stb;
  assign bus1.wishbone_addr_i = adr;
  assign bus1.wishbone_we_i   = we;
  assign bus1.wishbone_data_i = wdat;

  wire        ack_o     = sel ? bus1.wishbone_ack : bus0.wishbone_ack;
  wire [31:0] dat_o     = sel ? bus1.wishbone_data_o : bus0.wishbone_data_o;
  wire [1:0]  state_sel = sel ? bus1.dbg_state : bus0.dbg_state;
  wire        irq_sel   = sel ? irq1 : irq0;

  ai_vec_mac_wb #(.ELEM_W(8), .DEPTH(16), .ACC_W(32)) u_dut0 (
    .wishbone_clk_i(clk), .wishbone_rst_i(rst), .bus(bus0), .irq_o(irq0));
  ai_vec_mac_wb #(.ELEM_W(8), .DEPTH(16), .ACC_W(20)) u_dut1 (
    .wishbone_clk_i(clk), .wishbone_rst_i(rst), .bus(bus1), .irq_o(irq1));

  // Clock
  always #5 clk = ~clk;

  // Running count of cycles the selected engine spends outside idle.
  always @(negedge clk) if (state_sel != 2'd0) busy_total <= busy_total + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus access; lat is the number of edges until ack was seen.
  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] r, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack_o && lat < 8);
    r = dat_o;
    n_assert++;
    assert (ack_o === 1'b1) else begin
      n_fail++;
      $error("FAIL ack_timeout: no ack for addr 0x%08h after %0d cycles (required ack)", a, lat);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    wb_access(a, 1'b1, d, r, lat);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    int lat;
    wb_access(a, 1'b0, 32'd0, r, lat);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (state_sel != 2'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_assert++;
    assert (state_sel == 2'd0) else begin
      n_fail++;
      $error("FAIL %s: still busy after %0d cycles (required idle)", tag, n);
    end
    @(negedge clk);
  endtask

  // Exact integer dot product, wrapping after each word and flagging any
  // partial result outside the accumulator range.
  function automatic void model(input int len, input bit sgn, input int accw,
                                output logic [31:0] res, output bit ovf);
    longint acc, s, tot, lo, hi, t, va, vb;
    logic [7:0] ea, eb;
    acc = 0;
    ovf = 1'b0;
    if (sgn) begin
      lo = -(longint'(1) << (accw - 1));
      hi = (longint'(1) << (accw - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << accw) - 1;
    end
    for (int w = 0; w < len; w++) begin
      s = 0;
      for (int l = 0; l < 4; l++) begin
        ea = a_m[w][8*l +: 8];
        eb = b_m[w][8*l +: 8];
        if (sgn) begin
          va = longint'($signed(ea));
          vb = longint'($signed(eb));
        end else begin
          va = longint'(ea);
          vb = longint'(eb);
        end
        s += va * vb;
      end
      tot = acc + s;
      if (tot < lo || tot > hi) ovf = 1'b1;
      t = tot & ((longint'(1) << accw) - 1);
      if (sgn && t > hi) t -= (longint'(1) << accw);
      acc = t;
    end
    res = acc[31:0];
  endfunction

  task automatic load_and_run(input int len, input bit sgn, input bit irq_en, input string tag);
    logic [31:0] r, er;
    bit eo;
    int b0;
    for (int w = 0; w < len; w++) begin
      wr(32'h400 + 32'(4 * w), a_m[w]);
      wr(32'h800 + 32'(4 * w), b_m[w]);
    end
    wr(32'h8, 32'(len));
    b0 = busy_total;
    wr(32'h0, {28'd0, irq_en, sgn, 2'b01});
    wait_idle(tag);
    model(len, sgn, sel ? 20 : 32, er, eo);
    chk($sformatf("%s_busy_cycles", tag), 32'(busy_total - b0), 32'(len + 2));
    rd(32'hC, r);
    chk($sformatf("%s_result", tag), r, er);
    rd(32'h4, r);
    chk($sformatf("%s_status", tag), r, {28'd0, 1'b0, eo, 2'b10});
  endtask

  initial begin
    logic [31:0] r;
    int lat, b0;

    // Reset state and bus timing
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rd(32'h4, r);  chk("reset_status", r, 32'h0);
    rd(32'hC, r);  chk("reset_result", r, 32'h0);
    rd(32'h0, r);  chk("reset_ctrl", r, 32'h0);
    chk("reset_irq", 32'(irq_sel), 32'h0);
    wb_access(32'hFFC, 1'b0, 32'd0, r, lat);
    chk("unmapped_read", r, 32'h0);
    chk("ack_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(ack_o), 32'h0);

    // Unsigned LEN=1 with interrupt, then clear
    a_m[0] = 32'h04030201; b_m[0] = 32'h01010101;
    load_and_run(1, 1'b0, 1'b1, "u_len1");
    chk("u_len1_irq", 32'(irq_sel), 32'h1);
    wr(32'h0, 32'h0000000A);
    chk("clear_irq", 32'(irq_sel), 32'h0);
    rd(32'h4, r);  chk("clear_status", r, 32'h0);
    rd(32'hC, r);  chk("clear_result", r, 32'h0);

    // Same operands in both modes
    a_m[0] = 32'hFFFFFFFF; b_m[0] = 32'h02020202;
    load_and_run(1, 1'b1, 1'b0, "s_neg");
    rd(32'hC, r);  chk("s_neg_const", r, 32'hFFFFFFF8);
    load_and_run(1, 1'b0, 1'b0, "u_big");
    rd(32'hC, r);  chk("u_big_const", r, 32'h000007F8);

    // Signed full-depth run with ignored mid-run accesses
    for (int w = 0; w < 16; w++) begin
      a_m[w] = 32'h7F7F7F7F; b_m[w] = 32'h7F7F7F7F;
      wr(32'h400 + 32'(4 * w), a_m[w]);
      wr(32'h800 + 32'(4 * w), b_m[w]);
    end
    wr(32'h8, 32'd16);
    b0 = busy_total;
    wr(32'h0, 32'h5);
    wr(32'h400, 32'h0);
    wr(32'h8, 32'd3);
    wr(32'h0, 32'h5);
    wr(32'h0, 32'h6);
    wait_idle("s_full");
    chk("s_full_busy_cycles", 32'(busy_total - b0), 32'd18);
    rd(32'hC, r);  chk("s_full_result", r, 32'h000FC040);
    rd(32'h4, r);  chk("s_full_status", r, 32'h2);
    rd(32'h400, r); chk("s_full_a0_kept", r, 32'h7F7F7F7F);
    rd(32'h8, r);  chk("s_full_len_kept", r, 32'd16);

    // Random runs on the 32-bit accumulator
    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int w = 0; w < len; w++) begin
        a_m[w] = $urandom; b_m[w] = $urandom;
      end
      load_and_run(len, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd32_%0d", k));
    end

    // 20-bit accumulator: overflow cases
    sel = 1'b1;
    for (int w = 0; w < 16; w++) begin
      a_m[w] = 32'hFFFFFFFF; b_m[w] = 32'hFFFFFFFF;
    end
    load_and_run(16, 1'b0, 1'b0, "acc20_full");
    rd(32'hC, r);  chk("acc20_full_const", r, 32'h000F8040);
    rd(32'h4, r);  chk("acc20_full_ovf", r, 32'h6);
    for (int k = 0; k < 6; k++) begin
      int len;
      len = $urandom_range(1, 16);
      for (int w = 0; w < len; w++) begin
        a_m[w] = $urandom; b_m[w] = $urandom;
      end
      load_and_run(len, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd20_%0d", k));
    end
    sel = 1'b0;

    // Invalid lengths raise err without a run
    wr(32'h8, 32'd0);
    b0 = busy_total;
    wr(32'h0, 32'h1);
    repeat (4) @(negedge clk);
    chk("len0_no_busy", 32'(busy_total - b0), 32'd0);
    rd(32'h4, r);  chk("len0_err", r & 32'h9, 32'h8);
    wr(32'h8, 32'd17);
    wr(32'h0, 32'h1);
    rd(32'h4, r);  chk("len17_err", r & 32'h9, 32'h8);

    // Valid start clears err, then reset mid-run
    for (int w = 0; w < 16; w++) begin
      wr(32'h400 + 32'(4 * w), 32'h01010101);
      wr(32'h800 + 32'(4 * w), 32'h01010101);
    end
    wr(32'h8, 32'd16);
    wr(32'h0, 32'h9);
    rd(32'h4, r);  chk("restart_busy_no_err", r, 32'h1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_state", 32'(state_sel), 32'h0);
    chk("midrst_irq", 32'(irq_sel), 32'h0);
    rd(32'h4, r);  chk("midrst_status", r, 32'h0);
    rd(32'hC, r);  chk("midrst_result", r, 32'h0);
    repeat (25) @(negedge clk);
    chk("midrst_no_irq_later", 32'(irq_sel), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
